// File: rtl/reveal_flood_if.sv
// Request/reveal bus between a requester (master) and the reveal_flood engine (slave).
interface reveal_flood_if #(
    parameter int IDX_W = 6
);
    logic             req_valid;
    logic [IDX_W-1:0] req_index;
    logic             req_ready;
    logic [IDX_W-1:0] tile_index;
    logic             reveal;
    logic             hit_mine;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_index,
        input  req_ready, tile_index, reveal, hit_mine, busy, done
    );

    modport slave (
        input  req_valid, req_index,
        output req_ready, tile_index, reveal, hit_mine, busy, done
    );
endinterface

// File: rtl/reveal_flood.sv
// Flood-fill reveal engine: one reveal pulse per tile reached from a zero-count request.
// Optional macro REVEAL_FLOOD_STATS_EN adds o_last_count (pulses issued by the last request).
module reveal_flood #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    reveal_flood_if.slave        bus,
    input  logic [ROWS*COLS-1:0] i_mine_map,
    input  logic [ROWS*COLS-1:0] i_flagged,
    input  logic [ROWS*COLS-1:0] i_revealed
`ifdef REVEAL_FLOOD_STATS_EN
    ,
    output logic [IDX_W:0]       o_last_count
`endif
);
    localparam int N = ROWS * COLS;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_ISSUE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [N-1:0]     r_pending;
    logic [N-1:0]     r_visited;
    logic [IDX_W-1:0] r_p;
    logic             r_mine_req;
    logic             r_reveal;
    logic             r_hit_mine;
    logic             r_done;
    logic             r_busy;
    logic             r_ready;

    logic [IDX_W-1:0] w_low_idx;
    logic             w_skip;
    logic [N-1:0]     w_nb_mask;
    logic             w_nb_zero;
    logic [N-1:0]     w_expand;
    logic             w_reveal_nx;
    logic             w_hit_nx;
    logic             w_done_nx;
    logic             w_busy_nx;
    logic             w_ready_nx;
    int               w_row;
    int               w_col;

    // Lowest set bit of the pending set (loop runs high to low so the lowest wins).
    always_comb begin
        w_low_idx = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_idx = IDX_W'(i);
            end else begin
                w_low_idx = w_low_idx;
            end
        end
        w_skip = i_revealed[w_low_idx] | i_flagged[w_low_idx] | r_visited[w_low_idx];
    end

    // In-bounds neighbours of the tile being issued; out-of-range cells OR in a zero.
    always_comb begin
        w_row     = int'(r_p) / COLS;
        w_col     = int'(r_p) % COLS;
        w_nb_mask = {N{1'b0}};
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                w_nb_mask[IDX_W'((w_row + dr) * COLS + w_col + dc)] |=
                    !(dr == 0 && dc == 0) &&
                    (w_row + dr >= 0) && (w_row + dr < ROWS) &&
                    (w_col + dc >= 0) && (w_col + dc < COLS);
            end
        end
        w_nb_zero = ~|(w_nb_mask & i_mine_map);
        w_expand  = w_nb_mask & ~i_mine_map & ~i_flagged & ~i_revealed & ~r_visited;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_state_nx = S_SELECT;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_SELECT: begin
                if (r_pending == {N{1'b0}}) begin
                    w_state_nx = S_DONE;
                end else if (w_skip) begin
                    w_state_nx = S_SELECT;
                end else begin
                    w_state_nx = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nx = S_SELECT;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        w_reveal_nx = (w_state_nx == S_ISSUE);
        w_hit_nx    = (w_state_nx == S_ISSUE) & r_mine_req;
        w_done_nx   = (w_state_nx == S_DONE);
        w_busy_nx   = (w_state_nx != S_IDLE);
        w_ready_nx  = (w_state_nx == S_IDLE);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reveal   <= 1'b0;
            r_hit_mine <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_reveal   <= w_reveal_nx;
            r_hit_mine <= w_hit_nx;
            r_done     <= w_done_nx;
            r_busy     <= w_busy_nx;
            r_ready    <= w_ready_nx;
        end
    end

    // Walk datapath: pending set, visited guard, selected tile, latched mine flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending  <= {N{1'b0}};
            r_visited  <= {N{1'b0}};
            r_p        <= {IDX_W{1'b0}};
            r_mine_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_visited  <= {N{1'b0}};
                        r_pending  <= {{(N-1){1'b0}}, 1'b1} << bus.req_index;
                        r_mine_req <= i_mine_map[bus.req_index] & ~i_flagged[bus.req_index];
                    end else begin
                        r_pending <= r_pending;
                    end
                end
                S_SELECT: begin
                    if (r_pending != {N{1'b0}}) begin
                        r_pending[w_low_idx] <= 1'b0;
                        if (!w_skip) begin
                            r_p <= w_low_idx;
                        end else begin
                            r_p <= r_p;
                        end
                    end else begin
                        r_pending <= r_pending;
                    end
                end
                S_ISSUE: begin
                    r_visited[r_p] <= 1'b1;
                    if (!r_mine_req && w_nb_zero) begin
                        r_pending <= r_pending | w_expand;
                    end else begin
                        r_pending <= r_pending;
                    end
                end
                S_DONE:  r_pending <= r_pending;
                default: r_pending <= r_pending;
            endcase
        end
    end

`ifdef REVEAL_FLOOD_STATS_EN
    logic [IDX_W:0] r_issue_cnt;
    logic [IDX_W:0] r_last_count;

    // Per-request pulse counter, published when the request completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_cnt  <= {(IDX_W+1){1'b0}};
            r_last_count <= {(IDX_W+1){1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_issue_cnt <= {(IDX_W+1){1'b0}};
                    end else begin
                        r_issue_cnt <= r_issue_cnt;
                    end
                end
                S_ISSUE: r_issue_cnt  <= r_issue_cnt + {{IDX_W{1'b0}}, 1'b1};
                S_DONE:  r_last_count <= r_issue_cnt;
                default: r_issue_cnt  <= r_issue_cnt;
            endcase
        end
    end

    assign o_last_count = r_last_count;
`endif

    assign bus.req_ready  = r_ready;
    assign bus.tile_index = r_p;
    assign bus.reveal     = r_reveal;
    assign bus.hit_mine   = r_hit_mine;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_reveal_flood.sv
// Directed bench for reveal_flood on an 8x8 board with a tile-state model and reveal scoreboard.
module tb_reveal_flood;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] mines = 64'd0;
    logic [63:0] flags = 64'd0;
    logic [63:0] rev;
    logic        clr_rev = 1'b1;
    logic        clr_obs = 1'b1;

    int n_chk = 0;
    int n_pass = 0;
    int exp_q[$];
    bit exp_hit_q[$];
    int obs_idx[128];
    bit obs_hit[128];
    int obs_cnt;
    int stray_hit;

    reveal_flood_if #(.IDX_W(6)) bus ();

`ifdef REVEAL_FLOOD_STATS_EN
    logic [6:0] last_count;
`endif

    reveal_flood #(.ROWS(8), .COLS(8), .IDX_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .i_mine_map (mines),
        .i_flagged  (flags),
        .i_revealed (rev)
`ifdef REVEAL_FLOOD_STATS_EN
        ,
        .o_last_count (last_count)
`endif
    );

    always #5 clk = ~clk;

    // Tile-state block: revealed bit set one clock after the pulse.
    always @(posedge clk) begin
        if (clr_rev) rev <= 64'd0;
        else if (bus.reveal) rev[bus.tile_index] <= 1'b1;
    end

    // Monitor: records every reveal pulse and any hit_mine without a reveal.
    always @(negedge clk) begin
        if (clr_obs) begin
            obs_cnt   <= 0;
            stray_hit <= 0;
        end else begin
            if (bus.reveal === 1'b1 && obs_cnt < 128) begin
                obs_idx[obs_cnt] <= int'(bus.tile_index);
                obs_hit[obs_cnt] <= bus.hit_mine;
                obs_cnt <= obs_cnt + 1;
            end
            if (bus.hit_mine === 1'b1 && bus.reveal !== 1'b1) stray_hit <= stray_hit + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic clear_all();
        clr_rev = 1'b1;
        clr_obs = 1'b1;
        tick();
        clr_rev = 1'b0;
        clr_obs = 1'b0;
    endtask

    // Reference flood walk: pushes expected tile order and hit flag onto the scoreboard.
    task automatic model(input int req, input logic [63:0] m, input logic [63:0] f,
                         input logic [63:0] r);
        logic [63:0] pend;
        logic [63:0] vis;
        bit mreq;
        bit zero;
        int p, rr, cc, q;
        pend = 64'd0;
        vis = 64'd0;
        pend[req] = 1'b1;
        mreq = m[req] & ~f[req];
        while (pend != 64'd0) begin
            p = 0;
            for (int i = 63; i >= 0; i--) if (pend[i]) p = i;
            pend[p] = 1'b0;
            if (!(r[p] | f[p] | vis[p])) begin
                exp_q.push_back(p);
                exp_hit_q.push_back(mreq);
                vis[p] = 1'b1;
                r[p] = 1'b1;
                if (!mreq) begin
                    zero = 1'b1;
                    for (int dr = -1; dr <= 1; dr++)
                        for (int dc = -1; dc <= 1; dc++) begin
                            rr = p / 8 + dr;
                            cc = p % 8 + dc;
                            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                                if (m[rr*8+cc]) zero = 1'b0;
                        end
                    if (zero)
                        for (int dr = -1; dr <= 1; dr++)
                            for (int dc = -1; dc <= 1; dc++) begin
                                rr = p / 8 + dr;
                                cc = p % 8 + dc;
                                if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                                    q = rr * 8 + cc;
                                    if (!m[q] && !f[q] && !r[q] && !vis[q]) pend[q] = 1'b1;
                                end
                            end
                end
            end
        end
    endtask

    // Issue one request (ready-bounded), then wait for done; lat = edges from accept to done.
    task automatic start_req(input int idx);
        for (int k = 0; k < 50 && bus.req_ready !== 1'b1; k++) tick();
        bus.req_valid = 1'b1;
        bus.req_index = 6'(idx);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
        check({tag, "_done_seen"}, bus.done, 1);
    endtask

    task automatic compare_obs(input string tag);
        int e;
        bit h;
        check({tag, "_count"}, obs_cnt, exp_q.size());
        for (int i = 0; i < obs_cnt && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            h = exp_hit_q.pop_front();
            check({tag, "_idx"}, obs_idx[i], e);
            check({tag, "_hit"}, obs_hit[i], h);
        end
        exp_q.delete();
        exp_hit_q.delete();
        check({tag, "_stray_hit"}, stray_hit, 0);
    endtask

    function automatic int count_idx(input int a, input int b);
        int c = 0;
        for (int i = 0; i < obs_cnt; i++) if (obs_idx[i] == a || obs_idx[i] == b) c++;
        return c;
    endfunction

    initial begin
        int lat;
        int saved;
        bus.req_valid = 1'b0;
        bus.req_index = 6'd0;

        // 1: reset state
        repeat (3) tick();
        check("rst_reveal", bus.reveal, 0);
        check("rst_hit", bus.hit_mine, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_tile", bus.tile_index, 0);
        check("rst_ready", bus.req_ready, 1);
        rst = 1'b1;
        clear_all();
        tick();

        // 2: mine hit
        mines = 64'd0;
        mines[10] = 1'b1;
        exp_q.push_back(10);
        exp_hit_q.push_back(1'b1);
        start_req(10);
        wait_done("hit", lat);
        check("hit_latency", lat, 3);
        compare_obs("hit");
        tick();
        check("hit_busy_after", bus.busy, 0);
        check("hit_ready_after", bus.req_ready, 1);

        // 3: empty board, ascending 0..63
        clear_all();
        mines = 64'd0;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(i);
            exp_hit_q.push_back(1'b0);
        end
        start_req(0);
        wait_done("full", lat);
        check("full_latency", lat, 129);
        compare_obs("full");
`ifdef REVEAL_FLOOD_STATS_EN
        tick();
        check("full_last_count", last_count, 64);
`endif

        // 4: mine at 63 only
        clear_all();
        mines = 64'd0;
        mines[63] = 1'b1;
        model(0, mines, flags, 64'd0);
        start_req(0);
        wait_done("m63", lat);
        check("m63_total", obs_cnt, 63);
        check("m63_no63", count_idx(63, 63), 0);
        compare_obs("m63");

        // 5: flag at 9, then request the flagged tile
        clear_all();
        mines = 64'd0;
        flags = 64'd0;
        flags[9] = 1'b1;
        model(0, mines, flags, 64'd0);
        start_req(0);
        wait_done("flag", lat);
        check("flag_total", obs_cnt, 63);
        check("flag_no9", count_idx(9, 9), 0);
        compare_obs("flag");
        clr_obs = 1'b1;
        tick();
        clr_obs = 1'b0;
        start_req(9);
        wait_done("flag9", lat);
        check("flag9_latency", lat, 2);
        check("flag9_pulses", obs_cnt, 0);
        flags = 64'd0;

        // 6: mine at 8, req 7; a request pulsed mid-walk must be ignored
        clear_all();
        mines = 64'd0;
        mines[8] = 1'b1;
        model(7, mines, flags, 64'd0);
        start_req(7);
        repeat (5) tick();
        check("busy_ready_low", bus.req_ready, 0);
        bus.req_valid = 1'b1;
        bus.req_index = 6'd0;
        tick();
        bus.req_valid = 1'b0;
        wait_done("wrap", lat);
        check("wrap_total", obs_cnt, 62);
        check("wrap_no0_no8", count_idx(0, 8), 0);
        compare_obs("wrap");
        repeat (3) tick();
        check("wrap_idle_after", bus.busy, 0);

        // reset mid-walk
        clear_all();
        mines = 64'd0;
        start_req(0);
        repeat (10) tick();
        rst = 1'b0;
        #1;
        saved = obs_cnt;
        check("abort_started", saved > 0, 1);
        check("abort_reveal", bus.reveal, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_ready", bus.req_ready, 1);
        check("abort_tile", bus.tile_index, 0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (20) tick();
        check("abort_no_pulses", obs_cnt, saved);
        check("abort_idle", bus.busy, 0);
        check("abort_no_done", bus.done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
